// File: rtl/instr_pkg.sv
// Shared definitions for the instruction queue: word format and issue FSM states.
package instr_pkg;

  // Default instruction word width and field positions (op/rx/ry/data).
  localparam int unsigned InstrWidth = 23;

  localparam int unsigned OpMsb   = 22;
  localparam int unsigned OpLsb   = 21;
  localparam int unsigned RxMsb   = 20;
  localparam int unsigned RxLsb   = 17;
  localparam int unsigned RyMsb   = 16;
  localparam int unsigned RyLsb   = 13;
  localparam int unsigned DataMsb = 12;
  localparam int unsigned DataLsb = 0;

  // Packed view of one instruction word; field order matches the bit positions above.
  typedef struct packed {
    logic [OpMsb-OpLsb:0]     op;
    logic [RxMsb-RxLsb:0]     rx;
    logic [RyMsb-RyLsb:0]     ry;
    logic [DataMsb-DataLsb:0] data;
  } instr_t;

  // Issue FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: storage array, wrapping pointers and occupancy counter.
module sync_fifo #(
  parameter int unsigned Width = 23,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned LevelW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;

  // Next-state for pointers and occupancy; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are not cleared on reset, the pointers make them unreachable.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Flags and head word, all derived from registered state.
  always_comb begin
    full_o  = (level_q == LevelW'(Depth));
    empty_o = (level_q == '0);
    level_o = level_q;
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/instr_queue.sv
// Instruction queue: program-load FIFO plus an issue FSM handing words to the processor.
module instr_queue
  import instr_pkg::*;
#(
  parameter int unsigned WIDTH = InstrWidth,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write,
  input  logic [WIDTH-1:0]       program_in,
  input  logic                   start,
  output logic [WIDTH-1:0]       instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned LevelW = $clog2(DEPTH) + 1;

  state_e state_q;
  logic   busy_q;
  logic   overflow_q;
  logic   push, pop;

  sync_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .wdata_i (program_in),
    .pop_i   (pop),
    .rdata_o (instr_out),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Handshake: a pop frees a slot, so a write while full is still accepted in that cycle.
  always_comb begin
    instr_valid = (state_q == StRun) && !empty;
    pop         = instr_valid && instr_ready;
    push        = write && (!full || pop);
    busy        = busy_q;
    overflow    = overflow_q;
  end

  // Issue FSM with busy registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !empty) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          // Last word leaves with nothing arriving behind it.
          if (pop && !push && (level == LevelW'(1))) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          // Wait for start to drop so a held start cannot restart issue.
          if (!start) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a write dropped because the queue was full with no pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (write && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 23, meaning instruction word width (op/rx/ry/data format).
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of queue entries; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port write, input, 1 bit: program-load strobe; enqueues program_in this cycle.
REQ-006 SHALL have port program_in, input, WIDTH bits: instruction word to enqueue; ignored, and may be X/Z, when write=0.
REQ-007 SHALL have port start, input, 1 bit: level request to begin issuing queued instructions.
REQ-008 SHALL have port instr_out, output, WIDTH bits: head-of-queue instruction presented to the processor.
REQ-009 SHALL have port instr_valid, output, 1 bit: instr_out holds a valid instruction.
REQ-010 SHALL have port instr_ready, input, 1 bit: the processor accepts instr_out this cycle.
REQ-011 SHALL have ports full and empty, output, 1 bit each: queue occupancy flags.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag for a write attempted while full.
REQ-014 SHALL have port busy, output, 1 bit: high in state RUN.

Function
REQ-015 SHALL implement a first-word-fall-through FIFO; instr_out SHALL equal the oldest stored entry whenever empty=0.
REQ-016 SHALL perform a push when write=1 and (full=0 or a pop occurs in the same cycle).
REQ-017 SHALL perform a pop when instr_valid=1 and instr_ready=1.
REQ-018 SHALL, on a simultaneous push and pop, leave level unchanged and enqueue the new word behind the remaining entries.
REQ-019 SHALL, when write=1, full=1 and no pop occurs, drop the word, leave the contents unchanged, and set overflow until reset.
REQ-020 SHALL wrap read and write pointers modulo DEPTH.
REQ-021 SHALL derive full = (level==DEPTH) and empty = (level==0) from registered state.
REQ-022 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-023 SHALL transition IDLE->RUN when start=1 and empty=0; writes are accepted in every state.
REQ-024 SHALL transition RUN->DONE on the cycle in which a pop leaves the queue empty and no push occurs in that cycle.
REQ-025 SHALL transition DONE->IDLE when start=0; DONE SHALL hold while start=1 and SHALL NOT re-enter RUN while start stays high.
REQ-026 SHALL drive instr_valid = (state==RUN) and (empty=0), combinationally from registers.
REQ-027 SHALL make a word pushed while in RUN with an empty queue visible on instr_out with instr_valid=1 in the next cycle.
REQ-028 SHALL hold instr_out stable while instr_valid=1 and instr_ready=0.
REQ-029 SHALL ignore instr_ready when instr_valid=0.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set state=IDLE, both pointers=0, level=0, overflow=0, empty=1, full=0, instr_valid=0 and busy=0.
REQ-031 SHALL give reset priority over write, start and instr_ready in the same cycle.
REQ-032 SHALL, on reset during RUN, discard all queued entries; storage contents need not be cleared.
REQ-033 SHALL drive instr_out to all zeros when empty=1.

Structure
REQ-034 SHALL take the WIDTH default, the instruction field positions (op[22:21], rx[20:17], ry[16:13], data[12:0]) and the state enum from the shared package instr_pkg.
REQ-035 SHALL place the storage array, pointers and level counter in a single sub-module sync_fifo, with the FSM and handshake logic kept in instr_queue.

Verification
REQ-036 SHALL be verified by this scenario: reset, then write 23'h000009 and 23'h0A0003 in IDLE -> level=2, instr_valid=0, instr_out=23'h000009.
REQ-037 SHALL be verified by this scenario: start=1 with instr_ready=1 -> the two words issue on consecutive cycles in order, then DONE, busy=0, empty=1.
REQ-038 SHALL be verified by this scenario: fill 8 words, then a 9th write -> overflow=1, level=8, the 9th word is never issued.
REQ-039 SHALL be verified by this scenario: RUN with level=8, write and ready both high for one cycle -> level stays 8 and the new word lands last.
REQ-040 SHALL be verified by this scenario: instr_ready=0 for 3 cycles in RUN -> instr_out and instr_valid stay stable and level does not change.
REQ-041 SHALL be verified by this scenario: reset asserted mid-RUN with level=5 -> next cycle IDLE, level=0, instr_valid=0, overflow=0.
